life_support_monitor: RTL

Closed-loop supervisor downstream of the life-support stage. Consumes its registered oxygen, power, temperature and shield values and its fatal flag, then grades ship condition through a debounced alarm state machine. Drives the horn, evacuation and fault counter outputs. Generates the `o2sup` and `chrg` resupply requests that feed back into the life-support stage's inputs.

---
 rtl/life_support_monitor_pkg.sv | 43 ++++
 rtl/life_support_monitor_if.sv | 35 +++
 rtl/life_support_monitor_hyst_flag.sv | 37 +++
 rtl/life_support_monitor.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/life_support_monitor_pkg.sv
// Shared definitions for the life-support supervisor and its neighbours.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package ls_pkg;

    // Width of every monitored quantity coming out of the life-support stage.
    localparam int LS_N = 32;

    // Default grading thresholds and persistence window.
    localparam int unsigned O2_LOW_DEF     = 50;
    localparam int unsigned PWR_LOW_DEF    = 20;
    localparam int unsigned TEMP_HIGH_DEF  = 90;
    localparam int unsigned SHIELD_LOW_DEF = 10;
    localparam int unsigned HOLD_DEF       = 4;

    // Width of the saturating upward-transition counter.
    localparam int FAULT_W = 8;

    // Ship operating modes consumed by neighbouring blocks.
    localparam logic [3:0] MODE_DEFENCE = 4'b0100;
    localparam logic [3:0] MODE_STEALTH = 4'b1000;

    // Alarm level; the encoding is exported directly on the level output.
    typedef enum logic [1:0] {
        NOMINAL = 2'd0,
        CAUTION = 2'd1,
        WARNING = 2'd2,
        ABANDON = 2'd3
    } ls_level_e;

    // Level the ship condition is heading towards, from the number of raised flags.
    // ABANDON is never a target; only the fatal input reaches it.
    function automatic ls_level_e target_level(input logic [2:0] nflags);
        if (nflags == 3'd0) begin
            return NOMINAL;
        end else if (nflags == 3'd1) begin
            return CAUTION;
        end else begin
            return WARNING;
        end
    endfunction

endpackage

// File: rtl/life_support_monitor_if.sv
// Bundle between the life-support stage / crew panel and the supervisor.
// Latency: none (wires only).
// Backpressure: none; every signal is sampled or driven every cycle.
interface life_support_monitor_if #(
    parameter int N = ls_pkg::LS_N
);
    // Registered quantities from the life-support stage.
    logic [N-1:0] outo2;
    logic [N-1:0] outpower;
    logic [N-1:0] outtemp;
    logic [N-1:0] outshield;
    logic         fatal;
    // Crew acknowledge.
    logic         ack;
    // Supervisor outputs.
    logic         o2sup;
    logic         chrg;
    logic [1:0]   level;
    logic         horn;
    logic         evac;
    logic [ls_pkg::FAULT_W-1:0] fault_cnt;

    // Life-support stage / crew side: drives the monitored values.
    modport master (
        output outo2, outpower, outtemp, outshield, fatal, ack,
        input  o2sup, chrg, level, horn, evac, fault_cnt
    );

    // Supervisor side.
    modport slave (
        input  outo2, outpower, outtemp, outshield, fatal, ack,
        output o2sup, chrg, level, horn, evac, fault_cnt
    );

endinterface

// File: rtl/life_support_monitor_hyst_flag.sv
// Hysteresis request flag: sets below LOW, clears at or above 2*LOW, else holds.
// Latency: 1 clock from threshold crossing to flag change.
// Backpressure: none; input sampled every edge.
module hyst_flag #(
    parameter int         N   = 32,
    parameter logic [N-1:0] LOW = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [N-1:0] i_val,
    output logic         o_flag
);

    // Clear threshold is doubled in N+1 bits so a large LOW cannot wrap.
    localparam logic [N:0] HIGH = {LOW, 1'b0};

    logic w_below;
    logic w_at_or_above_high;
    logic r_flag;

    assign w_below            = (i_val < LOW);
    assign w_at_or_above_high = ({1'b0, i_val} >= HIGH);

    // Set has priority; between the two thresholds the flag keeps its value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_flag <= 1'b0;
        end else if (w_below) begin
            r_flag <= 1'b1;
        end else if (w_at_or_above_high) begin
            r_flag <= 1'b0;
        end
    end

    assign o_flag = r_flag;

endmodule

// File: rtl/life_support_monitor.sv
// Grades ship condition into a debounced alarm level; drives horn/evac/faults and resupply requests.
// Latency: level moves after HOLD consecutive edges of a new target; fatal and thresholds act in 1 edge.
// Backpressure: none; inputs are sampled every edge and outputs are always valid.
module life_support_monitor
    import ls_pkg::*;
#(
    parameter int          N          = LS_N,
    parameter int unsigned O2_LOW     = O2_LOW_DEF,
    parameter int unsigned PWR_LOW    = PWR_LOW_DEF,
    parameter int unsigned TEMP_HIGH  = TEMP_HIGH_DEF,
    parameter int unsigned SHIELD_LOW = SHIELD_LOW_DEF,
    parameter int unsigned HOLD       = HOLD_DEF
) (
    input  logic clk,
    input  logic rst,
    life_support_monitor_if.slave bus
);

    // Counter is wide enough to hold the value HOLD itself.
    localparam int CW = $clog2(HOLD) + 1;

    localparam logic [N-1:0]  L_O2_LOW     = N'(O2_LOW);
    localparam logic [N-1:0]  L_PWR_LOW    = N'(PWR_LOW);
    localparam logic [N-1:0]  L_TEMP_HIGH  = N'(TEMP_HIGH);
    localparam logic [N-1:0]  L_SHIELD_LOW = N'(SHIELD_LOW);
    localparam logic [CW-1:0] L_HOLD       = CW'(HOLD);

    // Condition flags.
    logic      w_low_o2;
    logic      w_low_pwr;
    logic      w_hot;
    logic      w_weak;
    logic [2:0] w_nflags;
    ls_level_e w_target;

    // Alarm FSM and persistence tracking.
    ls_level_e     r_state;
    ls_level_e     w_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [CW-1:0] w_cnt_inc;
    logic          r_dir_up;
    logic          w_dir_next;
    logic          w_want_up;
    logic          w_step_up;

    // Registered outputs.
    logic               r_horn;
    logic               r_evac;
    logic [FAULT_W-1:0] r_fault_cnt;

    // Resupply hysteresis flags.
    logic w_o2_req;
    logic w_pwr_req;

    assign w_low_o2  = (bus.outo2     <  L_O2_LOW);
    assign w_low_pwr = (bus.outpower  <  L_PWR_LOW);
    assign w_hot     = (bus.outtemp   >= L_TEMP_HIGH);
    assign w_weak    = (bus.outshield <  L_SHIELD_LOW);

    assign w_nflags = {2'b00, w_low_o2} + {2'b00, w_low_pwr}
                    + {2'b00, w_hot}    + {2'b00, w_weak};
    assign w_target = target_level(w_nflags);

    // Alarm state, persistence count and last requested direction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= NOMINAL;
            r_cnt    <= '0;
            r_dir_up <= 1'b1;
        end else begin
            r_state  <= w_next;
            r_cnt    <= w_cnt_next;
            r_dir_up <= w_dir_next;
        end
    end

    // Next level: fatal jumps straight to ABANDON, otherwise one step per full HOLD window.
    // A direction flip restarts the window, with the flipping edge counted as its first.
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_dir_next = r_dir_up;
        w_want_up  = 1'b0;
        w_cnt_inc  = '0;
        w_step_up  = 1'b0;

        if (r_state == ABANDON) begin
            w_cnt_next = '0;
        end else if (bus.fatal) begin
            w_next     = ABANDON;
            w_cnt_next = '0;
            w_step_up  = 1'b1;
        end else if (w_target == r_state) begin
            w_cnt_next = '0;
        end else begin
            w_want_up  = (w_target > r_state);
            w_cnt_inc  = (w_want_up == r_dir_up) ? (r_cnt + CW'(1)) : CW'(1);
            w_dir_next = w_want_up;
            if (w_cnt_inc >= L_HOLD) begin
                w_next     = w_want_up ? ls_level_e'(r_state + 2'd1)
                                       : ls_level_e'(r_state - 2'd1);
                w_cnt_next = '0;
                w_step_up  = w_want_up;
            end else begin
                w_cnt_next = w_cnt_inc;
            end
        end
    end

    // Horn latches on any escalation, acknowledge silences it except in ABANDON.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_horn <= 1'b0;
        end else if (w_next == ABANDON) begin
            r_horn <= 1'b1;
        end else if (w_step_up) begin
            r_horn <= 1'b1;
        end else if (bus.ack) begin
            r_horn <= 1'b0;
        end
    end

    // Evacuate flag follows next-state so it rises together with level == ABANDON.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_evac <= 1'b0;
        end else begin
            r_evac <= (w_next == ABANDON);
        end
    end

    // Saturating count of upward level transitions.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault_cnt <= '0;
        end else if (w_step_up && (r_fault_cnt != {FAULT_W{1'b1}})) begin
            r_fault_cnt <= r_fault_cnt + FAULT_W'(1);
        end
    end

    hyst_flag #(
        .N   (N),
        .LOW (L_O2_LOW)
    ) u_o2_hyst (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_val  (bus.outo2),
        .o_flag (w_o2_req)
    );

    hyst_flag #(
        .N   (N),
        .LOW (L_PWR_LOW)
    ) u_pwr_hyst (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_val  (bus.outpower),
        .o_flag (w_pwr_req)
    );

    // Once abandoning, keep asking for everything regardless of levels.
    assign bus.o2sup     = w_o2_req  | (r_state == ABANDON);
    assign bus.chrg      = w_pwr_req | (r_state == ABANDON);
    assign bus.level     = r_state;
    assign bus.horn      = r_horn;
    assign bus.evac      = r_evac;
    assign bus.fault_cnt = r_fault_cnt;

endmodule
